uart_time_cmd_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver and decodes ASCII time/alarm
//  set commands for the digital clock core. A frame is 'T' or 'A', then six

---
 rtl/uart_time_cmd_parser.sv | 137 +++++++++++++
 tb/tb_uart_time_cmd_parser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_cmd_parser.sv
// uart_time_cmd_parser
// Decodes ASCII "T/A HHMMSS CR" frames from a UART byte stream into BCD time.
// Valid frames load the BCD outputs and pulse o_set_time / o_set_alarm.
// Malformed, out-of-range or timed-out frames pulse o_err.
module uart_time_cmd_parser #(
   parameter int               TMO_W       = 16,
   parameter logic [TMO_W-1:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx_done,
   input  logic [7:0] i_rx_data,
   output logic [7:0] o_hour_bcd,
   output logic [7:0] o_min_bcd,
   output logic [7:0] o_sec_bcd,
   output logic       o_set_time,
   output logic       o_set_alarm,
   output logic       o_err,
   output logic       o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_WAIT_CR} state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic             r_rx_d;
   logic             r_cmd_alarm;
   logic [2:0]       r_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic [3:0]       r_sh [0:5];
   logic [7:0]       r_hour, r_min, r_sec;
   logic             r_set_time, r_set_alarm, r_err;

   logic w_ev, w_is_cmd, w_is_digit, w_is_cr, w_range_ok, w_tmo_hit;
   logic w_restart, w_store, w_pass, w_err_nx;

   assign w_ev       = i_rx_done & ~r_rx_d;
   assign w_is_cmd   = (i_rx_data == 8'h54) || (i_rx_data == 8'h41);
   assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
   assign w_is_cr    = (i_rx_data == 8'h0D);
   // Shadow slots: 0/1 hour tens/units, 2/3 minute, 4/5 second.
   assign w_range_ok = ((r_sh[0] < 4'd2) || ((r_sh[0] == 4'd2) && (r_sh[1] <= 4'd3)))
                       && (r_sh[2] <= 4'd5) && (r_sh[4] <= 4'd5);
   // A byte event in the same cycle takes priority over the timeout.
   assign w_tmo_hit  = (TIMEOUT_CYC != '0) && (r_state != S_IDLE) && !w_ev
                       && (r_tmo == TIMEOUT_CYC);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   // Next-state decode and per-byte actions
   always_comb begin
      w_state_nx = r_state;
      w_restart  = 1'b0;
      w_store    = 1'b0;
      w_pass     = 1'b0;
      w_err_nx   = 1'b0;
      if (w_ev) begin
         if (w_is_cmd) begin
            w_restart  = 1'b1;
            w_state_nx = S_DIGITS;
         end else begin
            case (r_state)
               S_DIGITS: begin
                  if (w_is_digit) begin
                     w_store = 1'b1;
                     if (r_cnt == 3'd5) w_state_nx = S_WAIT_CR;
                  end else begin
                     w_err_nx   = 1'b1;
                     w_state_nx = S_IDLE;
                  end
               end
               S_WAIT_CR: begin
                  w_state_nx = S_IDLE;
                  if (w_is_cr && w_range_ok) w_pass   = 1'b1;
                  else                       w_err_nx = 1'b1;
               end
               default: w_state_nx = S_IDLE;
            endcase
         end
      end else if (w_tmo_hit) begin
         w_err_nx   = 1'b1;
         w_state_nx = S_IDLE;
      end
   end

   // Edge detect, frame bookkeeping, timeout counter and output registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rx_d      <= 1'b0;
         r_cmd_alarm <= 1'b0;
         r_cnt       <= 3'd0;
         r_tmo       <= '0;
         r_hour      <= 8'h00;
         r_min       <= 8'h00;
         r_sec       <= 8'h00;
         r_set_time  <= 1'b0;
         r_set_alarm <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rx_d      <= i_rx_done;
         r_set_time  <= w_pass & ~r_cmd_alarm;
         r_set_alarm <= w_pass & r_cmd_alarm;
         r_err       <= w_err_nx;
         if (w_restart) begin
            r_cmd_alarm <= (i_rx_data == 8'h41);
            r_cnt       <= 3'd0;
         end else if (w_store) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_pass) begin
            r_hour <= {r_sh[0], r_sh[1]};
            r_min  <= {r_sh[2], r_sh[3]};
            r_sec  <= {r_sh[4], r_sh[5]};
         end
         if (w_ev || (r_state == S_IDLE)) r_tmo <= '0;
         else if (r_tmo != TIMEOUT_CYC)   r_tmo <= r_tmo + 1'b1;
      end
   end

   // Shadow digit store; never visible at the outputs until a frame passes
   always_ff @(posedge i_clk) begin
      if (w_store) r_sh[r_cnt] <= i_rx_data[3:0];
   end

   assign o_hour_bcd  = r_hour;
   assign o_min_bcd   = r_min;
   assign o_sec_bcd   = r_sec;
   assign o_set_time  = r_set_time;
   assign o_set_alarm = r_set_alarm;
   assign o_err       = r_err;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_time_cmd_parser.sv
// Bench for uart_time_cmd_parser: three instances (timeout 40, disabled, default)
// share one input stream and are compared every cycle against a frame-level model.
module tb_uart_time_cmd_parser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;

   logic [7:0] hr [3];
   logic [7:0] mn [3];
   logic [7:0] sc [3];
   logic       st [3];
   logic       sa [3];
   logic       er [3];
   logic       bz [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_time_cmd_parser #(.TMO_W(16), .TIMEOUT_CYC(16'd40)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
      .o_hour_bcd(hr[0]), .o_min_bcd(mn[0]), .o_sec_bcd(sc[0]),
      .o_set_time(st[0]), .o_set_alarm(sa[0]), .o_err(er[0]), .o_busy(bz[0]));
   uart_time_cmd_parser #(.TMO_W(16), .TIMEOUT_CYC(16'd0)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
      .o_hour_bcd(hr[1]), .o_min_bcd(mn[1]), .o_sec_bcd(sc[1]),
      .o_set_time(st[1]), .o_set_alarm(sa[1]), .o_err(er[1]), .o_busy(bz[1]));
   uart_time_cmd_parser dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
      .o_hour_bcd(hr[2]), .o_min_bcd(mn[2]), .o_sec_bcd(sc[2]),
      .o_set_time(st[2]), .o_set_alarm(sa[2]), .o_err(er[2]), .o_busy(bz[2]));

   // Reference model state, one set per instance
   int         tmo_of [3] = '{40, 0, 50000};
   bit         m_prev [3];
   bit         m_busy [3];
   bit         m_alarm [3];
   int         m_n [3];
   int         m_idle [3];
   logic [3:0] m_d [3][6];
   logic [7:0] m_hr [3];
   logic [7:0] m_mn [3];
   logic [7:0] m_sc [3];
   bit         m_st [3];
   bit         m_sa [3];
   bit         m_er [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level model: one call per clock with the inputs seen at that edge.
   task automatic model_step(input int k, input bit rn, input bit d, input logic [7:0] b);
      bit ev;
      int h;
      if (!rn) begin
         m_prev[k] = 0; m_busy[k] = 0; m_alarm[k] = 0; m_n[k] = 0; m_idle[k] = 0;
         m_hr[k] = 8'h00; m_mn[k] = 8'h00; m_sc[k] = 8'h00;
         m_st[k] = 0; m_sa[k] = 0; m_er[k] = 0;
         return;
      end
      ev = d && !m_prev[k];
      m_prev[k] = d;
      m_st[k] = 0; m_sa[k] = 0; m_er[k] = 0;
      if (ev) begin
         m_idle[k] = 0;
         if (b == 8'h54 || b == 8'h41) begin
            m_busy[k] = 1; m_alarm[k] = (b == 8'h41); m_n[k] = 0;
         end else if (m_busy[k]) begin
            if (m_n[k] < 6) begin
               if (b >= 8'h30 && b <= 8'h39) begin
                  m_d[k][m_n[k]] = 4'(b - 8'h30);
                  m_n[k]++;
               end else begin
                  m_er[k] = 1; m_busy[k] = 0;
               end
            end else begin
               m_busy[k] = 0;
               h = m_d[k][0] * 10 + m_d[k][1];
               if (b == 8'h0D && h <= 23 && m_d[k][2] <= 5 && m_d[k][4] <= 5) begin
                  m_hr[k] = {m_d[k][0], m_d[k][1]};
                  m_mn[k] = {m_d[k][2], m_d[k][3]};
                  m_sc[k] = {m_d[k][4], m_d[k][5]};
                  if (m_alarm[k]) m_sa[k] = 1;
                  else            m_st[k] = 1;
               end else begin
                  m_er[k] = 1;
               end
            end
         end
      end else if (m_busy[k]) begin
         if (tmo_of[k] != 0 && m_idle[k] == tmo_of[k]) begin
            m_er[k] = 1; m_busy[k] = 0;
         end else begin
            m_idle[k]++;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hour%0d", k), hr[k], m_hr[k]);
         chk($sformatf("min%0d", k),  mn[k], m_mn[k]);
         chk($sformatf("sec%0d", k),  sc[k], m_sc[k]);
         chk($sformatf("set_time%0d", k),  st[k], m_st[k]);
         chk($sformatf("set_alarm%0d", k), sa[k], m_sa[k]);
         chk($sformatf("err%0d", k),  er[k], m_er[k]);
         chk($sformatf("busy%0d", k), bz[k], m_busy[k]);
      end
   endtask

   // Drive one clock: inputs applied at the falling edge, checked at the next one.
   task automatic cycle(input bit rn, input bit d, input logic [7:0] b);
      rst_n = rn; rx_done = d; rx_data = b;
      for (int k = 0; k < 3; k++) model_step(k, rn, d, b);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] b, input int hold, input int gap);
      repeat (hold) cycle(1'b1, 1'b1, b);
      repeat (gap)  cycle(1'b1, 1'b0, b);
   endtask

   // Last byte is sent with no trailing gap so its pulse can be checked directly.
   task automatic send_str(input string s, input int last_gap);
      for (int i = 0; i < s.len(); i++)
         send(s[i], 1, (i == s.len() - 1) ? last_gap : 2);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      int errs;
      logic [7:0] fr [8];
      @(negedge clk);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      chk("reset_hour", hr[0], 8'h00);
      chk("reset_busy", bz[0], 1'b0);

      // Basic time set
      send_str("T123045\r", 0);
      chk("t1_set_time", st[0], 1'b1);
      chk("t1_hour", hr[0], 8'h12);
      chk("t1_min", mn[0], 8'h30);
      chk("t1_sec", sc[0], 8'h45);
      chk("t1_err", er[0], 1'b0);
      idle(3);

      // Alarm set, then an out-of-range hour keeps the previous value
      send_str("A235959\r", 0);
      chk("t2_set_alarm", sa[0], 1'b1);
      chk("t2_hour", hr[0], 8'h23);
      idle(2);
      send_str("T240000\r", 0);
      chk("t2_err", er[0], 1'b1);
      chk("t2_hour_kept", hr[0], 8'h23);
      chk("t2_sec_kept", sc[0], 8'h59);
      idle(2);

      // Bad character, then restart inside a frame
      send_str("T12x", 0);
      chk("t3_err", er[0], 1'b1);
      idle(2);
      send_str("T0000", 2);
      send_str("T000001\r", 0);
      chk("t3_set_time", st[0], 1'b1);
      chk("t3_hour", hr[0], 8'h00);
      chk("t3_sec", sc[0], 8'h01);
      idle(2);

      // Held i_rx_done counts once; five digits then CR is rejected
      send(8'h54, 5, 2);
      send_str("12345\r", 0);
      chk("t5_short_err", er[0], 1'b1);
      idle(2);
      send(8'h54, 5, 2);
      send_str("214500\r", 0);
      chk("t5_set_time", st[0], 1'b1);
      chk("t5_hour", hr[0], 8'h21);
      idle(2);

      // Reset mid-frame
      send_str("T1230", 2);
      cycle(1'b0, 1'b0, 8'h00);
      chk("t6_hour", hr[0], 8'h00);
      chk("t6_busy", bz[0], 1'b0);
      errs = 0;
      send_str("45\r", 2);
      chk("t6_no_pulse", {29'd0, st[0], sa[0], er[0]}, 32'd0);

      // Default timeout fires exactly once; disabled timeout keeps the frame open
      send_str("T1", 2);
      errs = 0;
      for (int i = 0; i < 50005; i++) begin
         idle(1);
         if (er[2]) errs++;
      end
      chk("t4_err_count", errs, 1);
      chk("t4_busy_dflt", bz[2], 1'b0);
      chk("t4_busy_notmo", bz[1], 1'b1);
      send_str("23456\r", 0);
      chk("t4_notmo_set", st[1], 1'b1);
      chk("t4_notmo_hour", hr[1], 8'h12);
      idle(2);

      // Randomized frames with corruption, held strobes, long gaps and resets
      for (int f = 0; f < 250; f++) begin
         fr[0] = ($urandom_range(0, 1) != 0) ? 8'h54 : 8'h41;
         fr[1] = 8'h30 + 8'($urandom_range(0, 3));
         fr[2] = 8'h30 + 8'($urandom_range(0, 9));
         fr[3] = 8'h30 + 8'($urandom_range(0, 6));
         fr[4] = 8'h30 + 8'($urandom_range(0, 9));
         fr[5] = 8'h30 + 8'($urandom_range(0, 6));
         fr[6] = 8'h30 + 8'($urandom_range(0, 9));
         fr[7] = 8'h0D;
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 24) == 0) fr[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) cycle(1'b0, 1'b0, 8'h00);
            send(fr[i], $urandom_range(1, 3),
                 ($urandom_range(0, 29) == 0) ? 45 : $urandom_range(1, 8));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
